paddle_move_ctrl: RTL and testbench

Frame-synchronous motion controller for one pong paddle. It synchronises the raw up/down button inputs and steps the paddle's top-row register `paddle_Y` once per frame, with optional acceleration and clamping to the playfield. Its `paddle_Y` output drives the paddle draw logic's Y location, so the drawn paddle never tears mid-frame. Two instances are used, one per player.

---
 rtl/paddle_pkg.sv | 28 ++
 rtl/btn_sync.sv | 22 ++
 rtl/paddle_move_ctrl.sv | 152 +++++++++++++++
 tb/tb_paddle_move_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types, widths and playfield-geometry helpers for the pong paddle motion controller.
package paddle_pkg;

  localparam int COORD_W = 9;
  localparam int ARITH_W = 10;
  localparam int STEP_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  function automatic int calc_y_min(input int corr_y);
    return corr_y;
  endfunction

  function automatic int calc_y_max(input int game_height, input int paddle_height,
                                    input int corr_y);
    return corr_y + game_height - paddle_height;
  endfunction

  function automatic int calc_y_ctr(input int game_height, input int paddle_height,
                                    input int corr_y);
    return game_height / 2 - paddle_height / 2 + corr_y;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser bringing an asynchronous button level into the clk domain.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic synced
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/paddle_move_ctrl.sv
// Frame-synchronous paddle motion controller; define PADDLE_ACCEL_EN to build the
// per-frame acceleration, otherwise the paddle moves a constant STEP_MIN lines per frame.
module paddle_move_ctrl
  import paddle_pkg::*;
#(
  parameter int GAME_HEIGHT   = 272,
  parameter int PADDLE_HEIGHT = 100,
  parameter int CORR_Y        = 12,
  parameter int STEP_MIN      = 2,
  parameter int STEP_MAX      = 8,
  parameter int ACCEL_FRAMES  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_Paddle,
  input  logic         down_Paddle,
  input  logic         frame_tick,
  input  logic         move_en,
  input  logic         recenter,
  output logic [8:0]   paddle_Y,
  output logic         moving,
  output logic         at_top,
  output logic         at_bottom
);

  localparam logic [ARITH_W-1:0] Y_MIN = ARITH_W'(calc_y_min(CORR_Y));
  localparam logic [ARITH_W-1:0] Y_MAX = ARITH_W'(calc_y_max(GAME_HEIGHT, PADDLE_HEIGHT, CORR_Y));
  localparam logic [ARITH_W-1:0] Y_CTR = ARITH_W'(calc_y_ctr(GAME_HEIGHT, PADDLE_HEIGHT, CORR_Y));
  localparam logic [STEP_W-1:0]  STEP_LO = STEP_W'(STEP_MIN);

  logic up_s, dn_s;

  btn_sync u_up_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (up_Paddle),
    .synced (up_s)
  );

  btn_sync u_dn_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (down_Paddle),
    .synced (dn_s)
  );

  state_t               state_q, state_d, req;
  logic [COORD_W-1:0]   y_q, y_d;
  logic [ARITH_W-1:0]   y_ext, step_ext, y_up, y_dn, y_next;
  logic [STEP_W-1:0]    step_eff;
  logic                 at_top_d, at_bottom_d;

  always_comb begin
    req = IDLE;
    if (up_s && !dn_s)      req = UP;
    else if (dn_s && !up_s) req = DOWN;
  end

`ifdef PADDLE_ACCEL_EN
  localparam int                 CNT_W   = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(ACCEL_FRAMES - 1);
  localparam logic [STEP_W-1:0]  STEP_HI = STEP_W'(STEP_MAX);

  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
  logic              clamped;

  // A continuing move keeps its accumulated speed; any entry or reversal restarts slow.
  always_comb begin
    step_eff = (req == state_q) ? step_q : STEP_LO;
    cnt_eff  = (req == state_q) ? cnt_q : '0;
    clamped  = ((req == UP) && (y_up == Y_MIN)) || ((req == DOWN) && (y_dn == Y_MAX));
    step_d   = step_q;
    cnt_d    = cnt_q;
    if (recenter || !move_en) begin
      step_d = STEP_LO;
      cnt_d  = '0;
    end else if (frame_tick) begin
      if (req == IDLE || clamped) begin
        step_d = STEP_LO;
        cnt_d  = '0;
      end else if (cnt_eff == CNT_END) begin
        cnt_d  = '0;
        step_d = (step_eff >= STEP_HI) ? STEP_HI : step_eff + 1'b1;
      end else begin
        cnt_d  = cnt_eff + 1'b1;
        step_d = step_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= STEP_LO;
      cnt_q  <= '0;
    end else begin
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign step_eff = STEP_LO;
`endif

  // Compare before subtracting so the 10-bit result never wraps below Y_MIN.
  always_comb begin
    y_ext    = {1'b0, y_q};
    step_ext = ARITH_W'(step_eff);
    y_up     = (y_ext >= Y_MIN + step_ext) ? y_ext - step_ext : Y_MIN;
    y_dn     = (y_ext + step_ext >= Y_MAX) ? Y_MAX : y_ext + step_ext;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    y_next  = y_ext;
    if (recenter) begin
      state_d = IDLE;
      y_next  = Y_CTR;
    end else if (!move_en) begin
      state_d = IDLE;
    end else if (frame_tick) begin
      state_d = req;
      case (req)
        UP:      y_next = y_up;
        DOWN:    y_next = y_dn;
        default: y_next = y_ext;
      endcase
    end
    y_d         = COORD_W'(y_next);
    at_top_d    = (y_next == Y_MIN);
    at_bottom_d = (y_next == Y_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      y_q       <= COORD_W'(Y_CTR);
      at_top    <= 1'b0;
      at_bottom <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      at_top    <= at_top_d;
      at_bottom <= at_bottom_d;
    end
  end

  assign paddle_Y = y_q;
  assign moving   = (state_q != IDLE);

endmodule

// File: tb/tb_paddle_move_ctrl.sv
// Self-checking bench for paddle_move_ctrl: directed scenarios plus randomized play
// compared against a frame-level reference model of paddle position and speed.
module tb_paddle_move_ctrl;

  localparam int Y_MIN  = 12;
  localparam int Y_MAX  = 184;
  localparam int Y_CTR  = 98;
  localparam int S_MIN  = 2;
  localparam int S_MAX  = 8;
  localparam int AF     = 4;
`ifdef PADDLE_ACCEL_EN
  localparam int EXP_UP10 = 70;
`else
  localparam int EXP_UP10 = 78;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       up_Paddle = 1'b0;
  logic       down_Paddle = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_en = 1'b1;
  logic       recenter = 1'b0;
  logic [8:0] paddle_Y;
  logic       moving, at_top, at_bottom;

  int checks = 0;
  int errors = 0;

  // Reference model: position, current direction (0 none, 1 up, 2 down), and the
  // number of consecutive unclamped moves made in that direction.
  int m_pos = Y_CTR;
  int m_dir = 0;
  int m_run = 0;
  int cur_dir = 0;

  paddle_move_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .up_Paddle   (up_Paddle),
    .down_Paddle (down_Paddle),
    .frame_tick  (frame_tick),
    .move_en     (move_en),
    .recenter    (recenter),
    .paddle_Y    (paddle_Y),
    .moving      (moving),
    .at_top      (at_top),
    .at_bottom   (at_bottom)
  );

  always #5 clk = ~clk;

  function automatic int model_speed();
`ifdef PADDLE_ACCEL_EN
    int s;
    s = S_MIN + m_run / AF;
    return (s > S_MAX) ? S_MAX : s;
`else
    return S_MIN;
`endif
  endfunction

  task automatic model_idle();
    m_dir = 0;
    m_run = 0;
  endtask

  task automatic model_frame(input int dir);
    int s;
    if (dir == 0) begin
      model_idle();
    end else begin
      if (dir != m_dir) m_run = 0;
      m_dir = dir;
      s = model_speed();
      if (dir == 1) m_pos = (m_pos - s < Y_MIN) ? Y_MIN : m_pos - s;
      else          m_pos = (m_pos + s > Y_MAX) ? Y_MAX : m_pos + s;
      if (m_pos == Y_MIN || m_pos == Y_MAX) m_run = 0;
      else                                  m_run++;
    end
  endtask

  task automatic set_btn(input logic u, input logic d);
    @(negedge clk);
    up_Paddle   = u;
    down_Paddle = d;
    cur_dir = (u && !d) ? 1 : (d && !u) ? 2 : 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (move_en) model_frame(cur_dir);
    else         model_idle();
  endtask

  task automatic do_recenter();
    @(negedge clk);
    recenter = 1'b1;
    @(negedge clk);
    recenter = 1'b0;
    m_pos = Y_CTR;
    model_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (paddle_Y !== 9'(Y_CTR) || moving !== 1'b0 || at_top !== 1'b0 || at_bottom !== 1'b0) begin
      errors++;
      $display("FAIL reset: Y=%0d mv=%b top=%b bot=%b, want Y=%0d mv=0 top=0 bot=0",
               paddle_Y, moving, at_top, at_bottom, Y_CTR);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_up();
    do_recenter();
    set_btn(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      frame();
      checks++;
      if (paddle_Y !== 9'(m_pos) || moving !== 1'b1) begin
        errors++;
        $display("FAIL hold_up frame %0d: Y=%0d mv=%b, want Y=%0d mv=1", i, paddle_Y, moving, m_pos);
      end
    end
    checks++;
    if (paddle_Y !== 9'(EXP_UP10)) begin
      errors++;
      $display("FAIL hold_up_10: Y=%0d want %0d", paddle_Y, EXP_UP10);
    end
    set_btn(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame();
    checks++;
    if (paddle_Y !== 9'(EXP_UP10) || moving !== 1'b0) begin
      errors++;
      $display("FAIL release: Y=%0d mv=%b want Y=%0d mv=0", paddle_Y, moving, EXP_UP10);
    end
  endtask

  task automatic test_clamp();
    set_btn(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      frame();
      checks++;
      if (paddle_Y !== 9'(m_pos) || int'(paddle_Y) < Y_MIN) begin
        errors++;
        $display("FAIL clamp_up frame %0d: Y=%0d want %0d", i, paddle_Y, m_pos);
      end
    end
    checks++;
    if (paddle_Y !== 9'(Y_MIN) || at_top !== 1'b1 || at_bottom !== 1'b0) begin
      errors++;
      $display("FAIL at_top: Y=%0d top=%b bot=%b want Y=%0d top=1 bot=0", paddle_Y, at_top, at_bottom, Y_MIN);
    end
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      frame();
      checks++;
      if (paddle_Y !== 9'(m_pos) || int'(paddle_Y) > Y_MAX) begin
        errors++;
        $display("FAIL clamp_dn frame %0d: Y=%0d want %0d", i, paddle_Y, m_pos);
      end
    end
    checks++;
    if (paddle_Y !== 9'(Y_MAX) || at_bottom !== 1'b1 || at_top !== 1'b0) begin
      errors++;
      $display("FAIL at_bottom: Y=%0d top=%b bot=%b want Y=%0d top=0 bot=1", paddle_Y, at_top, at_bottom, Y_MAX);
    end
  endtask

  task automatic test_both_buttons();
    int hold;
    do_recenter();
    set_btn(1'b0, 1'b1);
    frame();
    hold = m_pos;
    set_btn(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) frame();
    checks++;
    if (paddle_Y !== 9'(hold) || moving !== 1'b0) begin
      errors++;
      $display("FAIL both_buttons: Y=%0d mv=%b want Y=%0d mv=0", paddle_Y, moving, hold);
    end
  endtask

  task automatic test_move_en();
    int hold;
    set_btn(1'b1, 1'b0);
    frame();
    frame();
    hold = m_pos;
    @(negedge clk);
    move_en = 1'b0;
    @(negedge clk);
    model_idle();
    checks++;
    if (moving !== 1'b0 || paddle_Y !== 9'(hold)) begin
      errors++;
      $display("FAIL freeze_now: Y=%0d mv=%b want Y=%0d mv=0", paddle_Y, moving, hold);
    end
    for (int i = 0; i < 5; i++) frame();
    checks++;
    if (paddle_Y !== 9'(hold) || moving !== 1'b0) begin
      errors++;
      $display("FAIL move_en_low: Y=%0d mv=%b want Y=%0d mv=0", paddle_Y, moving, hold);
    end
    move_en = 1'b1;
  endtask

  task automatic test_recenter_tick();
    set_btn(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) frame();
    @(negedge clk);
    frame_tick = 1'b1;
    recenter   = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    recenter   = 1'b0;
    m_pos = Y_CTR;
    model_idle();
    checks++;
    if (paddle_Y !== 9'(Y_CTR) || moving !== 1'b0) begin
      errors++;
      $display("FAIL recenter_tick: Y=%0d mv=%b want Y=%0d mv=0", paddle_Y, moving, Y_CTR);
    end
  endtask

  task automatic test_reset_mid_move();
    set_btn(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) frame();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (paddle_Y !== 9'(Y_CTR) || moving !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: Y=%0d mv=%b want Y=%0d mv=0", paddle_Y, moving, Y_CTR);
    end
    up_Paddle = 1'b0;
    cur_dir = 0;
    @(negedge clk);
    rst = 1'b0;
    m_pos = Y_CTR;
    model_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        do_recenter();
      end else if (r == 1) begin
        @(negedge clk);
        move_en = ~move_en;
        @(negedge clk);
        if (!move_en) model_idle();
      end else begin
        if (r < 8) set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        frame();
      end
      checks++;
      if (paddle_Y !== 9'(m_pos) || moving !== (m_dir != 0) ||
          at_top !== (m_pos == Y_MIN) || at_bottom !== (m_pos == Y_MAX)) begin
        errors++;
        $display("FAIL random step %0d: Y=%0d mv=%b top=%b bot=%b want Y=%0d mv=%0d top=%0d bot=%0d",
                 i, paddle_Y, moving, at_top, at_bottom, m_pos, (m_dir != 0),
                 (m_pos == Y_MIN), (m_pos == Y_MAX));
      end
    end
    move_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_hold_up();
    test_clamp();
    test_both_buttons();
    test_move_en();
    test_recenter_tick();
    test_reset_mid_move();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
